// File: rtl/smu_uart_pkg.sv
// smu_uart_pkg: register offsets, STATUS bit indices and the shared TX/RX state enum.
package smu_uart_pkg;
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/smu_uart_fifo.sv
// smu_uart_fifo: 8-bit show-ahead FIFO; a push on a full FIFO succeeds only when paired with a pop.
module smu_uart_fifo
  import smu_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/smu_uart.sv
// smu_uart: memory-mapped 8N1 UART with TX/RX FIFOs.
// Receiver and RX FIFO exist only when SMU_UART_RX_EN is defined.
module smu_uart
  import smu_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cs_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  logic [3:0] off;
  logic wr, tx_push, tx_pop, tx_full, tx_fifo_empty, tx_empty, tx_bit_end;
  logic [7:0] tx_head, rx_head;
  logic rx_valid, rx_overrun;
  logic [3:0] status;
  uart_state_e tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic txd_q;
  logic unused;
  assign unused   = ^{addr[1:0], wdata[31:8], be[3:1]};
  assign off      = {addr[3:2], 2'b00};
  assign wr       = ~cs_n & we & be[0];
  assign tx_push  = wr & (off == OFF_DATA);
  assign uart_txd = txd_q;
  smu_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .n_rst(n_rst), .push(tx_push), .pop(tx_pop), .wdata(wdata[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_fifo_empty)
  );
  assign tx_bit_end = tx_cnt_q == BIT_END;
  // Popping at the end of STOP chains the next frame with no idle gap.
  assign tx_pop   = ~tx_fifo_empty & ((tx_state_q == IDLE) | ((tx_state_q == STOP) & tx_bit_end));
  assign tx_empty = tx_fifo_empty & (tx_state_q == IDLE);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= tx_head;
      txd_q      <= 1'b0;
    end else if (tx_state_q != IDLE) begin
      tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      if (tx_bit_end)
        case (tx_state_q)
          START: begin
            tx_state_q <= DATA;
            tx_bit_q   <= '0;
            txd_q      <= tx_sh_q[0];
          end
          DATA: begin
            tx_sh_q    <= tx_sh_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
            tx_state_q <= (tx_bit_q == 3'd7) ? STOP : DATA;
            txd_q      <= (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[1];
          end
          default: begin
            tx_state_q <= IDLE;
            txd_q      <= 1'b1;
          end
        endcase
    end
`ifdef SMU_UART_RX_EN
  logic [1:0] rx_sync_q;
  logic rxs, rx_push, rx_pop, rx_full, rx_empty, clr_ovr, rx_bit_end;
  uart_state_e rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic rx_overrun_q;
  assign rxs        = rx_sync_q[1];
  assign rx_bit_end = rx_cnt_q == BIT_END;
  assign rx_push    = (rx_state_q == STOP) & rx_bit_end & rxs;
  assign rx_valid   = ~rx_empty;
  assign rx_pop     = ~cs_n & re & (off == OFF_DATA) & rx_valid;
  assign clr_ovr    = wr & (off == OFF_CTRL) & wdata[0];
  assign rx_overrun = rx_overrun_q;
  smu_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .n_rst(n_rst), .push(rx_push), .pop(rx_pop), .wdata(rx_sh_q),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) rx_sync_q <= 2'b11;
    else rx_sync_q <= {rx_sync_q[0], uart_rxd};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rx_state_q   <= IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= (rx_push & rx_full & ~rx_pop) | (rx_overrun_q & ~clr_ovr);
      case (rx_state_q)
        IDLE: begin
          rx_cnt_q   <= '0;
          rx_state_q <= rxs ? IDLE : START;
        end
        START: begin
          rx_cnt_q   <= (rx_cnt_q == HALF_END) ? '0 : rx_cnt_q + 1'b1;
          rx_bit_q   <= '0;
          rx_state_q <= (rx_cnt_q != HALF_END) ? START : rxs ? IDLE : DATA;
        end
        DATA: begin
          rx_cnt_q <= rx_bit_end ? '0 : rx_cnt_q + 1'b1;
          if (rx_bit_end) begin
            rx_sh_q    <= {rxs, rx_sh_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            rx_state_q <= (rx_bit_q == 3'd7) ? STOP : DATA;
          end
        end
        default: begin
          rx_cnt_q   <= rx_bit_end ? '0 : rx_cnt_q + 1'b1;
          rx_state_q <= rx_bit_end ? IDLE : STOP;
        end
      endcase
    end
`else
  logic unused_rx;
  assign unused_rx  = ^{uart_rxd, re};
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_head    = '0;
`endif
  always_comb begin
    status                = '0;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    rdata = (off == OFF_DATA)   ? (rx_valid ? {24'b0, rx_head} : 32'b0) :
            (off == OFF_STATUS) ? {28'b0, status} : 32'b0;
  end
endmodule

// File: tb/tb_smu_uart.sv
// tb_smu_uart: randomized self-checking bench with a line-level 8N1 reference decoder.
module tb_smu_uart;
  localparam int CPB = 10;
  localparam int D   = 8;
  localparam int T   = 10;
  logic clk = 0, n_rst = 0, cs_n = 1, we = 0, re = 0, uart_rxd = 1;
  logic [3:0] addr = 0, be = 0;
  logic [31:0] wdata = 0, rdata, v;
  logic uart_txd;
  int n_chk = 0, n_bad = 0;
  logic [7:0] mon_q[$];
  logic [7:0] mon_b;
  logic [7:0] bytes[$];
  always #(T/2) clk = ~clk;
  smu_uart #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(D)) dut (
    .clk(clk), .n_rst(n_rst), .cs_n(cs_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] b, input int i);
    return (i == 0) ? 1'b0 : (i > 8) ? 1'b1 : b[i-1];
  endfunction
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk); cs_n = 0; we = 1; addr = a; wdata = d; be = b;
    @(posedge clk); #1 cs_n = 1; we = 0; be = 0;
  endtask
  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk); cs_n = 0; re = 1; addr = a;
    #1 d = rdata;
    @(posedge clk); #1 cs_n = 1; re = 0;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = (i == 9) ? stop : fbit(b, i);
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1;
    repeat (2*CPB) @(negedge clk);
  endtask
  // Independent line decoder: samples mid-bit, keeps only frames with a valid stop bit.
  initial forever begin
    @(negedge uart_txd);
    #(CPB*T/2 + 1);
    for (int i = 0; i < 8; i++) begin
      #(CPB*T);
      mon_b[i] = uart_txd;
    end
    #(CPB*T);
    if (uart_txd) mon_q.push_back(mon_b);
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, exp_n;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("txd_in_reset", uart_txd, 1);
    n_rst = 1;
    bus_rd(4'h4, v); check("status_reset", v, 32'h1);
    bus_rd(4'h8, v); check("ctrl_reads0", v, 0);
    bus_rd(4'hC, v); check("off_c_reads0", v, 0);
    bus_wr(4'h0, 32'h1AB, 4'b1110);
    bus_rd(4'h4, v); check("be0_low_dropped", v, 32'h1);
    bus_wr(4'h0, 32'h55, 4'hF);
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      check($sformatf("tx55_clk%0d", i), uart_txd, (i == 0) ? 1'b1 : fbit(8'h55, (i-1)/10));
    end
    repeat (3) @(negedge clk);
    bus_rd(4'h4, v); check("tx55_empty_after", v, 32'h1);
    check("tx55_mon_count", mon_q.size(), 1);
    if (mon_q.size() > 0) check("tx55_mon_byte", mon_q[0], 8'h55);
    for (int r = 0; r < 2; r++) begin
      mon_q.delete(); bytes.delete();
      n = (r == 0) ? 12 : int'($urandom_range(1, 12));
      // TX pops the first byte one clock after it lands, so a burst fits DEPTH+1 bytes.
      exp_n = (n < D + 1) ? n : D + 1;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        bytes.push_back(b);
        bus_wr(4'h0, {24'h0, b}, 4'hF);
        if (k == D) begin
          bus_rd(4'h4, v); check($sformatf("burst%0d_full", r), v, 32'h2);
        end
      end
      for (int c = 0; c < (exp_n + 2) * 10 * CPB && mon_q.size() < exp_n; c++) @(negedge clk);
      repeat (300) @(negedge clk);
      check($sformatf("burst%0d_count", r), mon_q.size(), exp_n);
      for (int k = 0; k < exp_n && k < mon_q.size(); k++)
        check($sformatf("burst%0d_byte%0d", r, k), mon_q[k], bytes[k]);
      bus_rd(4'h4, v); check($sformatf("burst%0d_idle", r), v, 32'h1);
    end
`ifdef SMU_UART_RX_EN
    send(8'hA3, 1);
    bus_rd(4'h4, v); check("rx_a3_status", v, 32'h5);
    bus_rd(4'h0, v); check("rx_a3_data", v, 32'hA3);
    bus_rd(4'h4, v); check("rx_a3_popped", v, 32'h1);
    bytes.delete();
    for (int k = 0; k < D + 1; k++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      send(b, 1);
    end
    bus_rd(4'h4, v); check("rx_overrun_status", v, 32'hD);
    for (int k = 0; k < D; k++) begin
      bus_rd(4'h0, v); check($sformatf("rx_fifo_byte%0d", k), v, {24'h0, bytes[k]});
    end
    bus_rd(4'h4, v); check("rx_drained_status", v, 32'h9);
    bus_wr(4'h8, 32'h1, 4'hF);
    bus_rd(4'h4, v); check("rx_overrun_clear", v, 32'h1);
    uart_rxd = 0; repeat (3) @(negedge clk); uart_rxd = 1;
    repeat (3*CPB) @(negedge clk);
    bus_rd(4'h4, v); check("rx_glitch", v, 32'h1);
    send(8'($urandom), 0);
    bus_rd(4'h4, v); check("rx_bad_stop", v, 32'h1);
    bus_rd(4'h0, v); check("rx_bad_stop_data", v, 0);
`else
    send(8'hA3, 1);
    bus_rd(4'h4, v); check("norx_status", v, 32'h1);
    bus_rd(4'h0, v); check("norx_data", v, 0);
`endif
    b = 8'($urandom) & 8'hF7;
    bus_wr(4'h0, {24'h0, b}, 4'hF);
    repeat (45) @(negedge clk);
    check("rst_mid_bit3_low", uart_txd, 0);
    #2 n_rst = 0;
    #1 check("rst_txd_immediate", uart_txd, 1);
    @(negedge clk); n_rst = 1;
    bus_rd(4'h4, v); check("rst_status", v, 32'h1);
    repeat (200) @(negedge clk);
    check("rst_txd_stays_idle", uart_txd, 1);
    bus_rd(4'h4, v); check("rst_status_late", v, 32'h1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
